// File: rtl/sha3_pkg.sv
// Shared constants and types for the SHA3 rate-block packer.
// Build option: PACKER_KECCAK_PAD_EN selects the original Keccak domain
// pad byte 0x01 instead of the FIPS-202 SHA3 pad byte 0x06.
package sha3_pkg;

   localparam int unsigned RATE_BYTES = 136;
   localparam int unsigned RATE_WORDS = 34;
   localparam int unsigned RATE_BITS  = RATE_BYTES * 8;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned LEN_W      = 32;
   localparam int unsigned CNT_W      = 6;
   localparam int unsigned BYTE_CNT_W = 8;
   localparam int unsigned PEND_W     = 2;

   localparam logic [7:0] PAD_END = 8'h80;
`ifdef PACKER_KECCAK_PAD_EN
   localparam logic [7:0] PAD_DOMAIN = 8'h01;
`else
   localparam logic [7:0] PAD_DOMAIN = 8'h06;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      PAD  = 2'd2,
      HOLD = 2'd3
   } state_t;

endpackage

// File: rtl/sha3_pad_gen.sv
// Combinational pad insertion for the final rate block.
// Ports: blk_in    - block holding the message tail (unused bytes are zero)
//        pad_pos   - byte index just past the message (msglen mod 136)
//        blk_pad_c - blk_in with domain pad XORed at pad_pos and 0x80 at byte 135
// Build option: PACKER_KECCAK_PAD_EN (via sha3_pkg) selects the domain pad byte.
module sha3_pad_gen
   import sha3_pkg::*;
(
   input  logic [RATE_BITS-1:0] blk_in,
   input  logic [7:0]           pad_pos,
   output logic [RATE_BITS-1:0] blk_pad_c
);

   // XOR both pad bytes so a coinciding byte naturally becomes 0x86 / 0x81
   always_comb begin
      blk_pad_c = blk_in;
      for (int unsigned i = 0; i < RATE_BYTES; i++) begin
         if (pad_pos == 8'(i)) begin
            blk_pad_c[i*8 +: 8] = blk_in[i*8 +: 8] ^ PAD_DOMAIN;
         end
      end
      blk_pad_c[RATE_BITS-1 -: 8] = blk_pad_c[RATE_BITS-1 -: 8] ^ PAD_END;
   end

endmodule

// File: rtl/sha3_blk_packer.sv
// Packs a byte message read as 32-bit little-endian FIFO words into padded
// 1088-bit SHA3 rate blocks.
// Ports: clk, rst (sync, active high)
//        start/msglen             - message start pulse and byte length
//        fifordy/fifoget/fifodout/fifovld - FIFO read side, data one cycle after get
//        blk_data/blk_vld/blk_rdy/blk_last - rate block output handshake
//        busy, done (pulse after last block accepted), err (sticky)
// Build option: PACKER_KECCAK_PAD_EN selects Keccak pad 0x01 instead of 0x06.
module sha3_blk_packer
   import sha3_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_W-1:0]     msglen,
   input  logic                 fifordy,
   output logic                 fifoget,
   input  logic [WORD_W-1:0]    fifodout,
   input  logic                 fifovld,
   output logic [RATE_BITS-1:0] blk_data,
   output logic                 blk_vld,
   input  logic                 blk_rdy,
   output logic                 blk_last,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   state_t                 state_q, state_d;
   logic [1:0]             tail_q, tail_d;
   logic [LEN_W-1:0]       rx_left_q, rx_left_d;
   logic [LEN_W-1:0]       req_left_q, req_left_d;
   logic [CNT_W-1:0]       blk_cnt_q, blk_cnt_d;
   logic [CNT_W-1:0]       blk_req_q, blk_req_d;
   logic [BYTE_CNT_W-1:0]  blk_bytes_q, blk_bytes_d;
   logic [PEND_W-1:0]      pend_q, pend_d;
   logic                   rst_dly_q;

   logic [RATE_BITS-1:0]   data_d;
   logic                   fifoget_d, blk_vld_d, blk_last_d, busy_d, done_d, err_d;

   logic                   vld_ok;
   logic [2:0]             nbytes;
   logic [WORD_W-1:0]      word_m;
   logic [LEN_W-1:0]       words;
   logic [RATE_BITS-1:0]   pad_c;

   sha3_pad_gen u_pad (
      .blk_in    (blk_data),
      .pad_pos   (blk_bytes_q),
      .blk_pad_c (pad_c)
   );

   // Next-state, counters and next-output values
   always_comb begin
      state_d     = state_q;
      tail_d      = tail_q;
      rx_left_d   = rx_left_q;
      req_left_d  = req_left_q;
      blk_cnt_d   = blk_cnt_q;
      blk_req_d   = blk_req_q;
      blk_bytes_d = blk_bytes_q;
      data_d      = blk_data;
      fifoget_d   = 1'b0;
      blk_vld_d   = blk_vld;
      blk_last_d  = blk_last;
      done_d      = 1'b0;
      err_d       = err;
      busy_d      = 1'b0;

      words  = LEN_W'(msglen[LEN_W-1:2]) + LEN_W'(|msglen[1:0]);
      vld_ok = fifovld && (pend_q != '0);
      pend_d = pend_q + PEND_W'(fifoget) - PEND_W'(vld_ok);

      // Final word keeps only the bytes that belong to the message
      nbytes = ((rx_left_q == LEN_W'(1)) && (tail_q != 2'd0)) ? {1'b0, tail_q} : 3'd4;
      word_m = fifodout;
      for (int unsigned j = 0; j < 4; j++) begin
         if (3'(j) >= nbytes) begin
            word_m[j*8 +: 8] = 8'h00;
         end
      end

      // Data arriving in the first cycle after reset belongs to an abandoned get
      if (fifovld && (pend_q == '0) && !rst_dly_q) begin
         err_d = 1'b1;
      end
      if (start && (state_q != IDLE)) begin
         err_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = FILL;
               tail_d      = msglen[1:0];
               rx_left_d   = words;
               req_left_d  = words;
               blk_cnt_d   = '0;
               blk_req_d   = '0;
               blk_bytes_d = '0;
               data_d      = '0;
               blk_last_d  = 1'b0;
            end
         end

         FILL: begin
            if (vld_ok && (rx_left_q != '0) && (blk_cnt_q < CNT_W'(RATE_WORDS))) begin
               for (int unsigned i = 0; i < RATE_WORDS; i++) begin
                  if (blk_cnt_q == CNT_W'(i)) begin
                     data_d[i*WORD_W +: WORD_W] = word_m;
                  end
               end
               blk_cnt_d   = blk_cnt_q + CNT_W'(1);
               blk_bytes_d = blk_bytes_q + BYTE_CNT_W'(nbytes);
               rx_left_d   = rx_left_q - LEN_W'(1);
            end
            if (fifordy && (blk_req_q < CNT_W'(RATE_WORDS)) && (req_left_q != '0)) begin
               fifoget_d  = 1'b1;
               blk_req_d  = blk_req_q + CNT_W'(1);
               req_left_d = req_left_q - LEN_W'(1);
            end
            // A message ending exactly on a block boundary still needs a pad-only block
            if ((rx_left_q == '0) &&
                !((blk_cnt_q == CNT_W'(RATE_WORDS)) && (blk_bytes_q == BYTE_CNT_W'(RATE_BYTES)))) begin
               state_d = PAD;
            end else if (blk_cnt_q == CNT_W'(RATE_WORDS)) begin
               state_d   = HOLD;
               blk_vld_d = 1'b1;
            end
         end

         PAD: begin
            data_d     = pad_c;
            blk_last_d = 1'b1;
            blk_vld_d  = 1'b1;
            state_d    = HOLD;
         end

         HOLD: begin
            if (blk_rdy) begin
               blk_vld_d = 1'b0;
               if (blk_last) begin
                  state_d    = IDLE;
                  done_d     = 1'b1;
                  blk_last_d = 1'b0;
               end else begin
                  state_d     = FILL;
                  data_d      = '0;
                  blk_cnt_d   = '0;
                  blk_req_d   = '0;
                  blk_bytes_d = '0;
               end
            end
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         tail_q      <= '0;
         rx_left_q   <= '0;
         req_left_q  <= '0;
         blk_cnt_q   <= '0;
         blk_req_q   <= '0;
         blk_bytes_q <= '0;
         pend_q      <= '0;
         rst_dly_q   <= 1'b1;
         blk_data    <= '0;
         fifoget     <= 1'b0;
         blk_vld     <= 1'b0;
         blk_last    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         state_q     <= state_d;
         tail_q      <= tail_d;
         rx_left_q   <= rx_left_d;
         req_left_q  <= req_left_d;
         blk_cnt_q   <= blk_cnt_d;
         blk_req_q   <= blk_req_d;
         blk_bytes_q <= blk_bytes_d;
         pend_q      <= pend_d;
         rst_dly_q   <= 1'b0;
         blk_data    <= data_d;
         fifoget     <= fifoget_d;
         blk_vld     <= blk_vld_d;
         blk_last    <= blk_last_d;
         busy        <= busy_d;
         done        <= done_d;
         err         <= err_d;
      end
   end

endmodule

// File: tb/tb_sha3_blk_packer.sv
// Self-checking bench for sha3_blk_packer: random messages, expected blocks
// built from the padding rules on a plain byte array.
// Build option: PACKER_KECCAK_PAD_EN switches the expected domain pad byte.
module tb_sha3_blk_packer;

`ifdef PACKER_KECCAK_PAD_EN
   localparam logic [7:0] DPAD = 8'h01;
`else
   localparam logic [7:0] DPAD = 8'h06;
`endif

   logic          clk, rst, start, fifordy, fifoget, fifovld_r, stray_vld;
   logic [31:0]   msglen, fifodout;
   logic [1087:0] blk_data;
   logic          blk_vld, blk_rdy, blk_last, busy, done, err;

   int            total, bad;
   logic [31:0]   word_mem [0:1023];
   int unsigned   rd_ptr, hold_gets;
   bit            rdy_mode;
   bit            exp_err;

   sha3_blk_packer dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .msglen   (msglen),
      .fifordy  (fifordy),
      .fifoget  (fifoget),
      .fifodout (fifodout),
      .fifovld  (fifovld_r | stray_vld),
      .blk_data (blk_data),
      .blk_vld  (blk_vld),
      .blk_rdy  (blk_rdy),
      .blk_last (blk_last),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // FIFO model: answers each get one cycle later with the next stored word
   initial begin
      bit g;
      fifovld_r = 1'b0;
      fifodout  = '0;
      rd_ptr    = 0;
      hold_gets = 0;
      forever begin
         @(negedge clk);
         g = fifoget;
         if (blk_vld && fifoget) hold_gets++;
         @(posedge clk);
         #1;
         if (g) begin
            fifovld_r = 1'b1;
            fifodout  = word_mem[rd_ptr % 1024];
            rd_ptr++;
         end else begin
            fifovld_r = 1'b0;
            fifodout  = $urandom;
         end
      end
   end

   initial begin
      fifordy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         fifordy = rdy_mode ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_blk(input string tag, input logic [1087:0] obs, input logic [1087:0] exp);
      int idx;
      idx = 0;
      for (int i = 135; i >= 0; i--) if (obs[i*8 +: 8] !== exp[i*8 +: 8]) idx = i;
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s byte=%0d observed=%02h expected=%02h", tag, idx, obs[idx*8 +: 8], exp[idx*8 +: 8]);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1'b0;
      exp_err = 1'b0;
   endtask

   // One message: store words, build expected padded bytes, run handshake
   task automatic run_msg(input int unsigned len, input int unsigned hmin, input int unsigned hmax,
                          input bit fixed, input bit poke);
      logic [7:0]    eb [0:543];
      logic [31:0]   w;
      logic [1087:0] exp;
      int unsigned   nw, nblk, base, h0, d, n;

      nw   = (len + 3) / 4;
      nblk = len / 136 + 1;
      base = rd_ptr;
      h0   = hold_gets;
      for (int i = 0; i < 544; i++) eb[i] = 8'h00;
      for (int unsigned k = 0; k < nw; k++) begin
         w = (fixed && k == 0) ? 32'hDDCCBBAA : $urandom;
         word_mem[(base + k) % 1024] = w;
         for (int unsigned j = 0; j < 4; j++) if (4*k + j < len) eb[4*k + j] = w[j*8 +: 8];
      end
      eb[len]            = eb[len] ^ DPAD;
      eb[nblk*136 - 1]   = eb[nblk*136 - 1] ^ 8'h80;

      @(posedge clk); #1 start = 1'b1; msglen = len;
      @(posedge clk); #1 start = 1'b0;

      for (int unsigned b = 0; b < nblk; b++) begin
         for (int i = 0; i < 136; i++) exp[i*8 +: 8] = eb[b*136 + i];
         n = 0;
         @(negedge clk);
         while (!blk_vld && n < 3000) begin
            @(negedge clk);
            n++;
         end
         chk($sformatf("blk_vld len=%0d b=%0d", len, b), 64'(blk_vld), 64'(1));
         chk("busy", 64'(busy), 64'(1));
         chk_blk($sformatf("blk_data len=%0d b=%0d", len, b), blk_data, exp);
         chk($sformatf("blk_last len=%0d b=%0d", len, b), 64'(blk_last), 64'(b == nblk - 1));
         d = $urandom_range(hmin, hmax);
         for (int unsigned t = 0; t < d; t++) begin
            @(posedge clk); #1;
            start = poke && b == 0 && t == 0;
            if (poke && b == 0 && t == 0) begin
               msglen  = 9;
               exp_err = 1'b1;
            end
            @(negedge clk);
            chk_blk("blk_hold", blk_data, exp);
            chk("vld_hold", 64'(blk_vld), 64'(1));
         end
         @(posedge clk); #1 blk_rdy = 1'b1; start = 1'b0;
         @(posedge clk); #1 blk_rdy = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("done len=%0d", len), 64'(done), 64'(1));
      @(negedge clk);
      chk("done_pulse", 64'(done), 64'(0));
      chk("busy_idle", 64'(busy), 64'(0));
      chk($sformatf("gets len=%0d", len), 64'(rd_ptr - base), 64'(nw));
      chk("hold_gets", 64'(hold_gets - h0), 64'(0));
      chk("err", 64'(err), 64'(exp_err));
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; start = 1'b0; msglen = '0; blk_rdy = 1'b0; stray_vld = 1'b0;
      rdy_mode = 1'b0; exp_err = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_fifoget", 64'(fifoget), 64'(0));
      chk("rst_blk_vld", 64'(blk_vld), 64'(0));
      chk("rst_blk_last", 64'(blk_last), 64'(0));
      chk_blk("rst_blk_data", blk_data, '0);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      @(posedge clk); #1 rst = 1'b0;

      run_msg(0,   0, 2, 1'b0, 1'b0);
      run_msg(3,   0, 2, 1'b1, 1'b0);
      run_msg(135, 0, 2, 1'b0, 1'b0);
      run_msg(136, 0, 2, 1'b0, 1'b0);
      rdy_mode = 1'b1;
      run_msg(200, 10, 10, 1'b0, 1'b0);
      rdy_mode = 1'b0;
      run_msg(137, 0, 3, 1'b0, 1'b0);
      run_msg(272, 0, 3, 1'b0, 1'b0);
      run_msg(1,   0, 3, 1'b0, 1'b0);
      run_msg(4,   0, 3, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) run_msg($urandom_range(0, 400), 0, 4, 1'b0, 1'b0);

      // start while busy is ignored and flags err
      run_msg(50, 3, 5, 1'b0, 1'b1);
      do_reset();
      @(negedge clk);
      chk("err_cleared", 64'(err), 64'(0));

      // unsolicited fifovld in IDLE flags err
      @(posedge clk); #1 stray_vld = 1'b1;
      @(posedge clk); #1 stray_vld = 1'b0;
      @(negedge clk);
      chk("err_stray", 64'(err), 64'(1));
      do_reset();

      // reset in the middle of FILL, stray data just after reset
      rdy_mode = 1'b1;
      @(posedge clk); #1 start = 1'b1; msglen = 400;
      @(posedge clk); #1 start = 1'b0;
      repeat (20) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0; stray_vld = 1'b1;
      @(posedge clk); #1 stray_vld = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_err", 64'(err), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_fifoget", 64'(fifoget), 64'(0));
      chk("midrst_blk_vld", 64'(blk_vld), 64'(0));
      exp_err = 1'b0;
      rdy_mode = 1'b0;
      run_msg(4, 0, 2, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sha3_blk_packer.md
SHA3_BLK_PACKER -- requirements
Module: sha3_blk_packer

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  in  1  one-cycle message-start pulse, honoured only in IDLE.
REQ-004 SHALL have port: msglen  in  32  message length in bytes, sampled with start.
REQ-005 SHALL have ports: fifordy  in  1  FIFO has data; fifoget  out  1  read pulse; fifodout  in  32  read data; fifovld  in  1  fifodout valid, exactly one cycle after fifoget.
REQ-006 SHALL have ports: blk_data  out  1088  rate block, byte i at bits [8i+7:8i]; blk_vld  out  1; blk_rdy  in  1; blk_last  out  1  final block of message.
REQ-007 SHALL have ports: busy  out  1  not IDLE; done  out  1  one-cycle pulse after last block accepted; err  out  1  sticky protocol error.

Function
REQ-010 SHALL use states IDLE, FILL, PAD, HOLD; start in IDLE -> FILL, latch msglen, clear buffer and counters.
REQ-011 SHALL consume ceil(msglen/4) words in total; each word maps little-endian: fifodout[7:0] is the lowest-addressed byte.
REQ-012 SHALL assert fifoget only in FILL, with fifordy=1 and requested-but-unreceived plus received words in the current block < 34 and < remaining message words; back-to-back gets allowed.
REQ-013 SHALL zero the bytes of the final word beyond msglen before storing them.
REQ-014 SHALL go FILL -> HOLD when 34 words are received and message bytes remain after the block or end exactly at the block boundary; FILL -> PAD when all message words are received and the block is not full.
REQ-015 SHALL, in PAD (one cycle), XOR the pad byte 0x06 at byte (msglen mod 136) and 0x80 at byte 135; if both coincide, the byte is 0x86; then -> HOLD with blk_last=1.
REQ-016 SHALL, when msglen mod 136 == 0 (including msglen=0), emit one extra all-padding block: byte0=0x06, byte135=0x80.
REQ-017 SHALL hold blk_vld=1 and blk_data/blk_last stable in HOLD until blk_rdy=1; no fifoget in HOLD.
REQ-018 SHALL, on blk_vld&blk_rdy: not last -> clear buffer, FILL; last -> IDLE with done=1 for one cycle.
REQ-019 SHALL ignore start when not IDLE and set err; SHALL set err on fifovld with no outstanding get, and drop that data.
REQ-020 SHALL emit floor(msglen/136)+1 blocks per message.

Reset
REQ-030 SHALL, on rst, go to IDLE next edge: fifoget=0, blk_vld=0, blk_last=0, blk_data=0, busy=0, done=0, err=0, counters=0.
REQ-031 SHALL abandon a message on rst mid-FILL/HOLD; any fifovld in the cycle after reset SHALL be ignored without setting err.

Configuration
REQ-040 SHALL, with PACKER_KECCAK_PAD_EN defined, use domain pad byte 0x01 (original Keccak) instead of 0x06; coinciding byte then 0x81.
REQ-041 SHALL, without PACKER_KECCAK_PAD_EN, use FIPS-202 SHA3 pad byte 0x06.

Structure
REQ-050 SHALL place RATE_BYTES=136, RATE_WORDS=34, pad constants and the state enum typedef in shared package sha3_pkg.
REQ-051 SHALL implement pad insertion (REQ-015/016/040) in combinational sub-module sha3_pad_gen; the FSM, counters and buffer stay in sha3_blk_packer.

Verification
REQ-060 msglen=0, start -> no fifoget; one block, byte0=0x06, byte135=0x80, rest 0, blk_last=1, done pulses after accept.
REQ-061 msglen=3, word 0xDDCCBBAA -> bytes0..3 = AA,BB,CC,06; byte135=0x80; DD discarded; one fifoget.
REQ-062 msglen=135 -> 34 gets; byte135=0x86, single block, blk_last=1.
REQ-063 msglen=136 -> 34 gets; block1 blk_last=0 with data only; block2 pure padding with blk_last=1.
REQ-064 blk_rdy low 10 cycles in HOLD with fifordy=1 -> blk_data stable, fifoget=0 throughout.
REQ-065 rst asserted mid-FILL, then start msglen=4 -> clean IDLE, err=0, correct single block output.
